// File: rtl/rename_pkg.sv
// Shared types for the rename-stage free-list controller.
package rename_pkg;
   localparam int PREG_W = 7;
   typedef logic [PREG_W-1:0] preg_t;
   typedef enum logic [1:0] {RUN, FLUSH, DRAIN} alloc_state_t;
endpackage

// File: rtl/rename_alloc_ctrl_release_fifo.sv
// Release queue: two writes per cycle (port 0 lands first), one read.
module release_fifo
   import rename_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = preg_t
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr0_en,
   input  T                           wr0_data,
   input  logic                       wr1_en,
   input  T                           wr1_data,
   input  logic                       rd_en,
   output T                           head,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] free_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   T               mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]  wa0, wa1;
   logic [CW-1:0]  cnt_q, cnt_d;

   always_comb begin
      wa0      = wr_ptr_q;
      wa1      = wr0_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
      wr_ptr_d = wr_ptr_q + AW'(wr0_en) + AW'(wr1_en);
      rd_ptr_d = rd_ptr_q + AW'(rd_en);
      cnt_d    = cnt_q + CW'(wr0_en) + CW'(wr1_en) - CW'(rd_en);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Payload needs no reset; occupancy alone decides validity.
   always_ff @(posedge clk) begin
      if (wr0_en) mem_q[wa0] <= wr0_data;
      if (wr1_en) mem_q[wa1] <= wr1_data;
   end

   assign head     = mem_q[rd_ptr_q];
   assign empty    = (cnt_q == '0);
   assign free_cnt = CW'(DEPTH) - cnt_q;
endmodule

// File: rtl/rename_alloc_ctrl.sv
// Free-list sequencer: round-robin pop arbitration, release merging and recovery blocking.
// state | meaning
// RUN   | normal operation, grants allowed
// FLUSH | recovery in progress, squash-walk returning tags
// DRAIN | walk done, waiting for release queue to empty
module rename_alloc_ctrl
   import rename_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int RELQ_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] alloc_req,
   output logic [NUM_REQ-1:0] alloc_gnt,
   output preg_t              alloc_preg,
   input  logic               commit_valid,
   input  preg_t              commit_preg,
   output logic               commit_ready,
   input  logic               squash_valid,
   input  preg_t              squash_preg,
   output logic               squash_ready,
   input  logic               flush_start,
   input  logic               flush_done,
   output logic               alloc_blocked,
   output logic               fl_pop,
   input  logic               fl_pop_ok,
   input  preg_t              fl_phy_rd,
   output logic               fl_push,
   output preg_t              fl_push_rd
);
   localparam int RRW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW  = $clog2(RELQ_DEPTH+1);

   alloc_state_t   state_q, state_d;
   logic [RRW-1:0] rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]  free_cnt, free_after;
   logic           rq_empty, push_priority, grant_ok, found, sq_en, cm_en, drain_done;
   preg_t          rq_head;
   int             idx;

   assign push_priority = (free_cnt == '0) || (state_q != RUN);
   assign grant_ok      = !rst && (state_q == RUN) && fl_pop_ok && (|alloc_req) && !push_priority;

   always_comb begin
      alloc_gnt = '0;
      found     = 1'b0;
      idx       = 0;
      rr_ptr_d  = rr_ptr_q;
      if (grant_ok) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!found && alloc_req[idx]) begin
               found          = 1'b1;
               alloc_gnt[idx] = 1'b1;
               rr_ptr_d       = RRW'((idx + 1) % NUM_REQ);
            end
         end
      end
   end

   assign fl_pop     = |alloc_gnt;
   assign alloc_preg = fl_phy_rd;
   assign fl_push    = !rst && !rq_empty && !fl_pop;
   assign fl_push_rd = rq_head;

   // Space freed by this cycle's dequeue is usable by this cycle's enqueue.
   assign free_after   = free_cnt + CW'(fl_push);
   assign squash_ready = !rst && (free_after >= CW'(1));
   assign commit_ready = !rst && (squash_valid ? (free_after >= CW'(2)) : (free_after >= CW'(1)));
   assign sq_en        = squash_valid && squash_ready;
   assign cm_en        = commit_valid && commit_ready;
   assign drain_done   = (free_after == CW'(RELQ_DEPTH)) && !sq_en && !cm_en;

   release_fifo #(.DEPTH(RELQ_DEPTH), .T(preg_t)) u_relq (
      .clk      (clk),
      .rst      (rst),
      .wr0_en   (sq_en),
      .wr0_data (squash_preg),
      .wr1_en   (cm_en),
      .wr1_data (commit_preg),
      .rd_en    (fl_push),
      .head     (rq_head),
      .empty    (rq_empty),
      .free_cnt (free_cnt)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:   if (flush_start) state_d = flush_done ? DRAIN : FLUSH;
         FLUSH: if (flush_done)  state_d = DRAIN;
         DRAIN: begin
            if (flush_start)     state_d = flush_done ? DRAIN : FLUSH;
            else if (drain_done) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   assign alloc_blocked = (state_q != RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= RUN;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end
endmodule

// File: tb/tb_rename_alloc_ctrl.sv
// Directed bench for rename_alloc_ctrl with hand-computed expectations.
module tb_rename_alloc_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] alloc_req;
   logic [1:0] alloc_gnt;
   logic [6:0] alloc_preg;
   logic       commit_valid;
   logic [6:0] commit_preg;
   logic       commit_ready;
   logic       squash_valid;
   logic [6:0] squash_preg;
   logic       squash_ready;
   logic       flush_start;
   logic       flush_done;
   logic       alloc_blocked;
   logic       fl_pop;
   logic       fl_pop_ok;
   logic [6:0] fl_phy_rd;
   logic       fl_push;
   logic [6:0] fl_push_rd;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   rename_alloc_ctrl #(.NUM_REQ(2), .RELQ_DEPTH(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .alloc_req     (alloc_req),
      .alloc_gnt     (alloc_gnt),
      .alloc_preg    (alloc_preg),
      .commit_valid  (commit_valid),
      .commit_preg   (commit_preg),
      .commit_ready  (commit_ready),
      .squash_valid  (squash_valid),
      .squash_preg   (squash_preg),
      .squash_ready  (squash_ready),
      .flush_start   (flush_start),
      .flush_done    (flush_done),
      .alloc_blocked (alloc_blocked),
      .fl_pop        (fl_pop),
      .fl_pop_ok     (fl_pop_ok),
      .fl_phy_rd     (fl_phy_rd),
      .fl_push       (fl_push),
      .fl_push_rd    (fl_push_rd)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // Advance one clock; free-list head model follows pops.
   task automatic cyc();
      logic p;
      p = fl_pop;
      @(posedge clk);
      #1;
      if (p) fl_phy_rd = fl_phy_rd + 7'd1;
   endtask

   task automatic drive(input logic [1:0] req, input logic cv, input logic [6:0] cp,
                        input logic sv, input logic [6:0] sp, input logic fs, input logic fd);
      alloc_req    = req;
      commit_valid = cv;
      commit_preg  = cp;
      squash_valid = sv;
      squash_preg  = sp;
      flush_start  = fs;
      flush_done   = fd;
      #2;
   endtask

   initial begin
      rst       = 1'b1;
      fl_pop_ok = 1'b1;
      fl_phy_rd = 7'd31;
      drive(2'b11, 1'b1, 7'd0, 1'b1, 7'd0, 1'b0, 1'b0);
      cyc();
      drive(2'b11, 1'b1, 7'd0, 1'b1, 7'd0, 1'b0, 1'b0);
      chk("rst_gnt", alloc_gnt, 0);
      chk("rst_pop", fl_pop, 0);
      chk("rst_push", fl_push, 0);
      chk("rst_cready", commit_ready, 0);
      chk("rst_sready", squash_ready, 0);
      cyc();
      rst = 1'b0;
      chk("rst_blocked", alloc_blocked, 0);

      // Round-robin grants
      drive(2'b01, 0, 0, 0, 0, 0, 0);
      chk("rr0_gnt", alloc_gnt, 2'b01);
      chk("rr0_preg", alloc_preg, 31);
      chk("rr0_pop", fl_pop, 1);
      cyc();
      drive(2'b11, 0, 0, 0, 0, 0, 0);
      chk("rr1_gnt", alloc_gnt, 2'b10);
      chk("rr1_preg", alloc_preg, 32);
      cyc();
      drive(2'b11, 0, 0, 0, 0, 0, 0);
      chk("rr2_gnt", alloc_gnt, 2'b01);
      chk("rr2_preg", alloc_preg, 33);
      cyc();

      // Commit release, push deferred behind a grant
      drive(2'b00, 1, 7'd5, 0, 0, 0, 0);
      chk("cm_ready", commit_ready, 1);
      chk("cm_nopush", fl_push, 0);
      cyc();
      drive(2'b01, 0, 0, 0, 0, 0, 0);
      chk("defer_gnt", alloc_gnt, 2'b01);
      chk("defer_push", fl_push, 0);
      chk("defer_preg", alloc_preg, 34);
      cyc();
      drive(2'b00, 0, 0, 0, 0, 0, 0);
      chk("cm_push", fl_push, 1);
      chk("cm_push_rd", fl_push_rd, 5);
      cyc();

      // Dual enqueue, squash first
      drive(2'b00, 1, 7'd9, 1, 7'd40, 0, 0);
      chk("dual_sready", squash_ready, 1);
      chk("dual_cready", commit_ready, 1);
      cyc();
      drive(2'b00, 0, 0, 0, 0, 0, 0);
      chk("dual_push0", fl_push_rd, 40);
      chk("dual_push0_v", fl_push, 1);
      cyc();
      drive(2'b00, 0, 0, 0, 0, 0, 0);
      chk("dual_push1", fl_push_rd, 9);
      cyc();
      drive(2'b00, 0, 0, 0, 0, 0, 0);
      chk("dual_empty", fl_push, 0);

      // Fill to full while lane 0 is granted every cycle
      drive(2'b01, 1, 7'd2, 1, 7'd1, 0, 0);
      chk("fill_a_gnt", alloc_gnt, 2'b01);
      cyc();
      drive(2'b01, 1, 7'd3, 0, 0, 0, 0);
      chk("fill_b_cready", commit_ready, 1);
      cyc();
      drive(2'b01, 1, 7'd99, 1, 7'd4, 0, 0);
      chk("one_slot_sready", squash_ready, 1);
      chk("one_slot_cready", commit_ready, 0);
      chk("one_slot_gnt", alloc_gnt, 2'b01);
      cyc();
      drive(2'b11, 0, 0, 0, 0, 0, 0);
      chk("full_gnt", alloc_gnt, 2'b00);
      chk("full_pop", fl_pop, 0);
      chk("full_push", fl_push, 1);
      chk("full_push_rd", fl_push_rd, 1);
      cyc();
      drive(2'b11, 0, 0, 0, 0, 0, 0);
      chk("resume_gnt", alloc_gnt, 2'b10);
      chk("resume_preg", alloc_preg, 38);
      chk("resume_push", fl_push, 0);
      cyc();
      for (int k = 2; k <= 4; k++) begin
         drive(2'b00, 0, 0, 0, 0, 0, 0);
         chk("drain_rd", fl_push_rd, k);
         cyc();
      end

      // Flush / drain sequence
      drive(2'b00, 0, 0, 0, 0, 1, 0);
      chk("fs_blocked", alloc_blocked, 0);
      cyc();
      drive(2'b11, 0, 0, 1, 7'd50, 0, 0);
      chk("fl1_blocked", alloc_blocked, 1);
      chk("fl1_gnt", alloc_gnt, 0);
      chk("fl1_push", fl_push, 0);
      cyc();
      drive(2'b11, 0, 0, 1, 7'd51, 0, 0);
      chk("fl2_gnt", alloc_gnt, 0);
      chk("fl2_push_rd", fl_push_rd, 50);
      cyc();
      drive(2'b11, 0, 0, 1, 7'd52, 0, 1);
      chk("fl3_blocked", alloc_blocked, 1);
      chk("fl3_push_rd", fl_push_rd, 51);
      cyc();
      drive(2'b11, 0, 0, 0, 0, 0, 0);
      chk("dr_blocked", alloc_blocked, 1);
      chk("dr_gnt", alloc_gnt, 0);
      chk("dr_push_rd", fl_push_rd, 52);
      cyc();
      drive(2'b11, 0, 0, 0, 0, 0, 0);
      chk("run_blocked", alloc_blocked, 0);
      chk("run_gnt", alloc_gnt, 2'b01);
      chk("run_preg", alloc_preg, 39);
      cyc();

      // Reset with queued entries during FLUSH
      drive(2'b01, 1, 7'd61, 1, 7'd60, 0, 0);
      cyc();
      drive(2'b01, 1, 7'd62, 0, 0, 0, 0);
      cyc();
      drive(2'b01, 0, 0, 0, 0, 1, 0);
      chk("pre_rst_push", fl_push, 0);
      cyc();
      drive(2'b00, 0, 0, 0, 0, 0, 0);
      chk("pre_rst_blocked", alloc_blocked, 1);
      chk("pre_rst_push_q", fl_push, 1);
      rst = 1'b1;
      #1;
      chk("in_rst_push", fl_push, 0);
      cyc();
      rst = 1'b0;
      drive(2'b00, 0, 0, 0, 0, 0, 0);
      chk("post_rst_blocked", alloc_blocked, 0);
      chk("post_rst_push", fl_push, 0);
      drive(2'b11, 0, 0, 0, 0, 0, 0);
      chk("post_rst_gnt", alloc_gnt, 2'b01);
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
